usb_data_buffer: RTL and testbench

//  Byte FIFO between the USB RX/TX engines and the AHB-lite slave. Packet-data sink for usb_rx
//  (store_rx_packet_data/rx_packet_data/flush) and packet-data source for usb_tx.

---
 rtl/usb_buffer_pkg.sv | 12 +
 rtl/usb_buffer_ram.sv | 25 ++
 rtl/usb_data_buffer.sv | 115 +++++++++++
 tb/tb_usb_data_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_buffer_pkg.sv
// Shared sizing constants and types for the USB packet-data FIFO.
package usb_buffer_pkg;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;
  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   occ_t;

endpackage

// File: rtl/usb_buffer_ram.sv
// DEPTH x DATA_W register file: one clocked write port and one asynchronous read port.
module usb_buffer_ram
  import usb_buffer_pkg::*;
(
  input  logic  clk,
  input  logic  i_we,
  input  ptr_t  i_waddr,
  input  byte_t i_wdata,
  input  ptr_t  i_raddr,
  output byte_t o_rdata
);

  byte_t r_mem [DEPTH];

  // NOTE: storage is deliberately not reset; pointers and occupancy define
  // which entries are valid, and an unreset array maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/usb_data_buffer.sv
// Shared half-duplex byte FIFO between usb_rx/usb_tx and the AHB slave:
// strobe arbitration, pointer/occupancy control, sticky error and registered read bytes.
module usb_data_buffer
  import usb_buffer_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  clear,
  input  logic  store_rx_packet_data,
  input  byte_t rx_packet_data,
  input  logic  store_tx_data,
  input  byte_t tx_data,
  input  logic  get_rx_data,
  output byte_t rx_data,
  input  logic  get_tx_packet_data,
  output byte_t tx_packet_data,
  output occ_t  buffer_occupancy,
  output logic  buffer_error
);

  ptr_t  r_wptr;
  ptr_t  r_rptr;
  occ_t  r_occ;
  occ_t  w_occ_next;
  byte_t r_rx_data;
  byte_t r_tx_data;
  logic  r_error;
  byte_t w_rdata;

  logic  w_empty_cmd;
  logic  w_wr;
  logic  w_rd;
  logic  w_rd_ok;
  logic  w_wr_ok;
  logic  w_err_evt;
  byte_t w_wdata;

  assign w_empty_cmd = flush | clear;
  assign w_wr        = store_rx_packet_data | store_tx_data;
  assign w_rd        = get_rx_data | get_tx_packet_data;
  assign w_wdata     = store_rx_packet_data ? rx_packet_data : tx_data;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign w_rd_ok = w_rd && (r_occ != '0);
  assign w_wr_ok = w_wr && ((r_occ < occ_t'(DEPTH)) || w_rd_ok);

  assign w_err_evt = (store_rx_packet_data & store_tx_data)
                   | (get_rx_data & get_tx_packet_data)
                   | (w_rd & ~w_rd_ok)
                   | (w_wr & ~w_wr_ok);

  usb_buffer_ram u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok & ~w_empty_cmd & ~rst),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // NOTE: every output of a combinational block gets a default first,
  // otherwise an uncovered case would infer a latch.
  always_comb begin
    w_occ_next = r_occ;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_occ_next = r_occ + 1'b1;
      2'b01:   w_occ_next = r_occ - 1'b1;
      default: w_occ_next = r_occ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_occ     <= '0;
      r_rx_data <= '0;
      r_tx_data <= '0;
      r_error   <= 1'b0;
    end else if (w_empty_cmd) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      if (clear) begin
        r_error <= 1'b0;
      end
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + 1'b1;
        if (get_rx_data) begin
          r_rx_data <= w_rdata;
        end
        if (get_tx_packet_data) begin
          r_tx_data <= w_rdata;
        end
      end
      r_occ <= w_occ_next;
      if (w_err_evt) begin
        r_error <= 1'b1;
      end
    end
  end

  assign rx_data          = r_rx_data;
  assign tx_packet_data   = r_tx_data;
  assign buffer_occupancy = r_occ;
  assign buffer_error     = r_error;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Scoreboard bench for usb_data_buffer: a byte queue models FIFO contents,
// shadow registers model the held output bytes and the sticky error flag.
module tb_usb_data_buffer;
  import usb_buffer_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  flush = 1'b0;
  logic  clear = 1'b0;
  logic  store_rx_packet_data = 1'b0;
  byte_t rx_packet_data = '0;
  logic  store_tx_data = 1'b0;
  byte_t tx_data = '0;
  logic  get_rx_data = 1'b0;
  byte_t rx_data;
  logic  get_tx_packet_data = 1'b0;
  byte_t tx_packet_data;
  occ_t  buffer_occupancy;
  logic  buffer_error;

  byte_t sb_q[$];
  byte_t m_rx = '0;
  byte_t m_tx = '0;
  logic  m_err = 1'b0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    peak = 0;

  usb_data_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .clear                (clear),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .buffer_error         (buffer_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_occ"}, 32'(buffer_occupancy), 32'(sb_q.size()));
    check({tag, "_err"}, 32'(buffer_error), 32'(m_err));
    check({tag, "_rx"},  32'(rx_data), 32'(m_rx));
    check({tag, "_tx"},  32'(tx_packet_data), 32'(m_tx));
  endtask

  // One cycle of stimulus; the model updates alongside, then DUT state is compared.
  task automatic op(input logic srx, input byte_t brx, input logic stx, input byte_t btx,
                    input logic grx, input logic gtx, input logic fl, input logic cl,
                    input string tag);
    bit    rd_ok;
    bit    wr_ok;
    byte_t b;
    store_rx_packet_data = srx; rx_packet_data = brx;
    store_tx_data = stx;        tx_data = btx;
    get_rx_data = grx;          get_tx_packet_data = gtx;
    flush = fl;                 clear = cl;
    if (fl || cl) begin
      sb_q.delete();
      if (cl) m_err = 1'b0;
    end else begin
      rd_ok = (grx || gtx) && (sb_q.size() > 0);
      wr_ok = (srx || stx) && ((sb_q.size() < DEPTH) || rd_ok);
      if ((srx && stx) || (grx && gtx) || ((grx || gtx) && !rd_ok) || ((srx || stx) && !wr_ok))
        m_err = 1'b1;
      if (rd_ok) begin
        b = sb_q.pop_front();
        if (grx) m_rx = b;
        if (gtx) m_tx = b;
      end
      if (wr_ok) sb_q.push_back(srx ? brx : btx);
    end
    step();
    store_rx_packet_data = 1'b0; store_tx_data = 1'b0;
    get_rx_data = 1'b0; get_tx_packet_data = 1'b0;
    flush = 1'b0; clear = 1'b0;
    if (sb_q.size() > peak) peak = sb_q.size();
    check_state(tag);
  endtask

  task automatic wr_rx(input byte_t b);
    op(1'b1, b, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, "wr_rx");
  endtask
  task automatic wr_tx(input byte_t b);
    op(1'b0, '0, 1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, "wr_tx");
  endtask
  task automatic rd_rx();
    op(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "rd_rx");
  endtask
  task automatic rd_tx();
    op(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, "rd_tx");
  endtask
  task automatic do_clear();
    op(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "clear");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    m_rx = '0; m_tx = '0; m_err = 1'b0;
    check_state("reset");
  endtask

  initial begin
    step();
    do_reset();

    // Fill to full, overflow, drain in order.
    for (int i = 0; i < 64; i++) wr_rx(byte_t'(i));
    check("t1_full", 32'(buffer_occupancy), 32'd64);
    wr_rx(8'hAA);
    check("t1_ovf_err", 32'(buffer_error), 32'd1);
    for (int i = 0; i < 64; i++) begin
      rd_rx();
      check("t1_order", 32'(rx_data), 32'(i));
    end
    check("t1_empty", 32'(buffer_occupancy), 32'd0);

    // Underflow on the usb_tx port leaves the output held.
    do_clear();
    check("t2_clr", 32'(buffer_error), 32'd0);
    rd_tx();
    check("t2_tx_hold", 32'(tx_packet_data), 32'd0);
    check("t2_udf_err", 32'(buffer_error), 32'd1);
    do_clear();
    check("t2_clr2", 32'(buffer_error), 32'd0);

    // Full FIFO with simultaneous AHB write and AHB read.
    for (int i = 0; i < 64; i++) wr_rx(byte_t'(8'h80 + i));
    op(1'b0, '0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, "t3_rw");
    check("t3_occ", 32'(buffer_occupancy), 32'd64);
    check("t3_err", 32'(buffer_error), 32'd0);
    check("t3_first", 32'(rx_data), 32'h80);
    for (int i = 0; i < 64; i++) rd_tx();
    check("t3_last", 32'(tx_packet_data), 32'h55);

    // Wrap-around with mixed write sources.
    peak = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) wr_rx(byte_t'($urandom_range(0, 255)));
      else wr_tx(byte_t'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 40; i++) rd_rx();
    for (int i = 0; i < 50; i++) begin
      if (i % 3 == 0) wr_tx(byte_t'($urandom_range(0, 255)));
      else wr_rx(byte_t'($urandom_range(0, 255)));
    end
    check("t4_peak", 32'(buffer_occupancy), 32'd50);
    for (int i = 0; i < 50; i++) begin
      if (i % 2 == 0) rd_tx();
      else rd_rx();
    end
    check("t4_peak_model", 32'(peak), 32'd50);

    // Flush wins over a same-cycle write.
    for (int i = 0; i < 10; i++) wr_rx(byte_t'(8'h20 + i));
    op(1'b1, 8'hEE, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, "t5_flush");
    check("t5_occ", 32'(buffer_occupancy), 32'd0);
    wr_rx(8'h12);
    rd_rx();
    check("t5_data", 32'(rx_data), 32'h12);

    // Dual-read collision: one pop, same byte on both outputs.
    wr_tx(8'h3C);
    op(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, "dual_rd");
    check("dual_rx", 32'(rx_data), 32'h3C);
    check("dual_tx", 32'(tx_packet_data), 32'h3C);
    check("dual_err", 32'(buffer_error), 32'd1);

    // Reset mid-transfer, then write collision.
    for (int i = 0; i < 20; i++) wr_tx(byte_t'(8'h60 + i));
    do_reset();
    check("t6_occ", 32'(buffer_occupancy), 32'd0);
    check("t6_rx0", 32'(rx_data), 32'd0);
    op(1'b1, 8'h31, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, "t6_wcol");
    check("t6_occ1", 32'(buffer_occupancy), 32'd1);
    check("t6_err", 32'(buffer_error), 32'd1);
    rd_rx();
    check("t6_rxkept", 32'(rx_data), 32'h31);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
